mem_port_arbiter: RTL and testbench

Shares one single-ported backing memory between the CPU instruction-fetch side (read-only) and the data side (read/write). Sits between the pipeline's IF/MEM stages and the unified memory model, serialising accesses with a req/ready handshake toward the CPU and a req/ack handshake toward memory. Data requests have fixed priority, with an anti-starvation guard for instruction fetch. Per-side stall outputs freeze the pipeline while a request is outstanding.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_sel.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_MAX_D_STREAK = 4;
  // Wide enough for the largest allowed streak limit (15)
  localparam int unsigned STREAK_W         = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - fixed-priority grant decision with fetch anti-starvation streak counter
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                i_forced;

  // Data wins unless fetch has been waiting through a full streak of data grants
  always_comb begin
    i_forced  = i_req_i && (streak_q == STREAK_MAX);
    grant_d_o = arb_en_i && d_req_i && !i_forced;
    grant_i_o = arb_en_i && i_req_i && !grant_d_o;
    streak_d  = streak_q;
    if (grant_d_o) begin
      if (!i_req_i) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end else if (grant_i_o) begin
      streak_d = '0;
    end
  end

  // Streak register, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ready_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              i_stall_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              arb_en;
  logic              grant_i, grant_d;

  assign arb_en = (state_q == ST_IDLE);

  mem_arb_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .arb_en_i (arb_en),
    .i_req_i  (i_req_i),
    .d_req_i  (d_req_i),
    .grant_i_o(grant_i),
    .grant_d_o(grant_d)
  );

  // Next-state: latch the winner in IDLE, hold the memory request until ack, pulse ready in RESP
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          state_d     = ST_GRANT_D;
        end else if (grant_i) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr_i;
          state_d    = ST_GRANT_I;
        end
      end
      ST_GRANT_I: begin
        if (mem_ack_i) begin
          i_rdata_d = mem_rdata_i;
          i_ready_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_GRANT_D: begin
        if (mem_ack_i) begin
          d_rdata_d = mem_rdata_i;
          d_ready_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_ready_o   = i_ready_q;
  assign d_ready_o   = d_ready_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign i_stall_o   = i_req_i & ~i_ready_q;
  assign d_stall_o   = d_req_i & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for the memory port arbiter
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int WAIT_MAX   = 60;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_ready_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ready_o;
  logic [31:0] d_rdata_o;
  logic        i_stall_o, d_stall_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX_STREAK)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
    .i_stall_o(i_stall_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mmem [0:255];
  bit          i_pend, d_pend, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  bit          busy, acked, ack_d, dut_idle_prev;
  bit          g_we;
  logic [31:0] g_addr, g_wdata, exp_rdata;
  logic [31:0] last_i_rdata, last_d_rdata;
  int          streak_m, cnt, i_wait, d_wait, cyc;
  int          grant_cyc, ready_cyc;
  int          i_pct, d_pct, keep_i_pct, keep_d_pct, stray_pct, dmin, dmax;
  bit          grants[$];

  task automatic drive();
    i_req_i   = i_pend;
    i_addr_i  = i_addr;
    d_req_i   = d_pend;
    d_we_i    = d_we;
    d_addr_i  = d_addr;
    d_wdata_i = d_wdata;
  endtask

  task automatic new_i();
    i_pend = 1'b1;
    i_addr = 32'($urandom_range(0, 255)) << 2;
  endtask

  task automatic new_d();
    d_pend  = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = 32'($urandom_range(0, 255)) << 2;
    d_wdata = $urandom;
  endtask

  task automatic init_model();
    i_pend = 0; d_pend = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    busy = 0; acked = 0; ack_d = 0; dut_idle_prev = 1;
    streak_m = 0; cnt = 0; i_wait = 0; d_wait = 0;
    last_i_rdata = '0; last_d_rdata = '0;
    i_pct = 0; d_pct = 0; keep_i_pct = 0; keep_d_pct = 0; stray_pct = 0; dmin = 0; dmax = 0;
    grant_cyc = -1; ready_cyc = -1;
    grants.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0; mem_ack_i = 1'b0;
    init_model();
    drive();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  // One cycle of the reference model: sample at negedge, check, respond as memory, then drive requests
  task automatic step();
    bit exp_ir, exp_dr, exp_grant, win_d;
    @(negedge clk);
    cyc++;
    exp_ir = acked && !ack_d;
    exp_dr = acked && ack_d;
    if (exp_ir) last_i_rdata = exp_rdata;
    if (exp_dr) last_d_rdata = exp_rdata;
    n_cmp += 6;
    if (i_ready_o !== exp_ir) begin n_err++; $display("FAIL i_ready cyc=%0d got=%b exp=%b", cyc, i_ready_o, exp_ir); end
    if (d_ready_o !== exp_dr) begin n_err++; $display("FAIL d_ready cyc=%0d got=%b exp=%b", cyc, d_ready_o, exp_dr); end
    if (i_stall_o !== (i_pend && !exp_ir)) begin n_err++; $display("FAIL i_stall cyc=%0d got=%b exp=%b", cyc, i_stall_o, i_pend && !exp_ir); end
    if (d_stall_o !== (d_pend && !exp_dr)) begin n_err++; $display("FAIL d_stall cyc=%0d got=%b exp=%b", cyc, d_stall_o, d_pend && !exp_dr); end
    if (i_rdata_o !== last_i_rdata) begin n_err++; $display("FAIL i_rdata cyc=%0d got=%h exp=%h", cyc, i_rdata_o, last_i_rdata); end
    if (d_rdata_o !== last_d_rdata) begin n_err++; $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata_o, last_d_rdata); end
    if (acked) begin
      n_cmp++;
      if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL mem_req_drop cyc=%0d got=%b exp=0", cyc, mem_req_o); end
      acked = 0; busy = 0; dut_idle_prev = 0;
      if (ready_cyc < 0) ready_cyc = cyc;
      if (ack_d) begin
        if ($urandom_range(0, 99) < keep_d_pct) new_d(); else d_pend = 0;
      end else begin
        if ($urandom_range(0, 99) < keep_i_pct) new_i(); else i_pend = 0;
      end
    end else if (busy) begin
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_we_o !== g_we || mem_addr_o !== g_addr || (g_we && mem_wdata_o !== g_wdata)) begin
        n_err++;
        $display("FAIL mem_hold cyc=%0d got=%b/%b/%h/%h exp=1/%b/%h/%h", cyc, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, g_we, g_addr, g_wdata);
      end
      dut_idle_prev = 0;
    end else begin
      exp_grant = dut_idle_prev && (i_pend || d_pend);
      n_cmp++;
      if (mem_req_o !== exp_grant) begin n_err++; $display("FAIL grant_time cyc=%0d got=%b exp=%b", cyc, mem_req_o, exp_grant); end
      if (mem_req_o === 1'b1) begin
        win_d = d_pend && !(i_pend && streak_m == MAX_STREAK);
        g_we    = win_d ? d_we : 1'b0;
        g_addr  = win_d ? d_addr : i_addr;
        g_wdata = d_wdata;
        n_cmp++;
        if (mem_we_o !== g_we || mem_addr_o !== g_addr || (g_we && mem_wdata_o !== g_wdata)) begin
          n_err++;
          $display("FAIL grant_winner cyc=%0d got=%b/%h/%h exp_d=%b %b/%h/%h", cyc, mem_we_o, mem_addr_o, mem_wdata_o, win_d, g_we, g_addr, g_wdata);
        end
        if (win_d) streak_m = i_pend ? ((streak_m < MAX_STREAK) ? streak_m + 1 : streak_m) : 0;
        else streak_m = 0;
        if (win_d) d_wait = 0; else i_wait = 0;
        grants.push_back(win_d);
        busy = 1; ack_d = win_d;
        cnt = $urandom_range(dmin, dmax);
        if (grant_cyc < 0) grant_cyc = cyc;
      end
      dut_idle_prev = (mem_req_o !== 1'b1);
    end
    // Memory responder
    mem_ack_i = 1'b0;
    if (busy) begin
      if (cnt == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = g_we ? $urandom : mmem[g_addr[9:2]];
        if (g_we) mmem[g_addr[9:2]] = g_wdata;
        exp_rdata = mem_rdata_i;
        acked = 1;
      end else begin
        cnt--;
      end
    end else if ($urandom_range(0, 99) < stray_pct) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = $urandom;
    end
    if (!i_pend && $urandom_range(0, 99) < i_pct) new_i();
    if (!d_pend && $urandom_range(0, 99) < d_pct) new_d();
    if (i_pend) i_wait++;
    if (d_pend) d_wait++;
    if (i_wait > WAIT_MAX || d_wait > WAIT_MAX) begin
      n_cmp++; n_err++;
      $display("FAIL starvation cyc=%0d i_wait=%0d d_wait=%0d limit=%0d", cyc, i_wait, d_wait, WAIT_MAX);
      i_wait = 0; d_wait = 0;
    end
    drive();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp += 9;
    if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%b exp=0", mem_req_o); end
    if (mem_we_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got=%b exp=0", mem_we_o); end
    if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_o); end
    if (mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata_o); end
    if (i_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_i_ready got=%b exp=0", i_ready_o); end
    if (d_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_d_ready got=%b exp=0", d_ready_o); end
    if (i_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_i_rdata got=%h exp=0", i_rdata_o); end
    if (d_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata_o); end
    if ({i_stall_o, d_stall_o} !== 2'b00) begin n_err++; $display("FAIL rst_stall got=%b exp=00", {i_stall_o, d_stall_o}); end
  endtask

  task automatic test_single_fetch();
    int t0;
    do_reset();
    i_pend = 1; i_addr = 32'h0000_0010;
    drive();
    t0 = cyc;
    repeat (6) step();
    n_cmp += 3;
    if (grant_cyc - t0 !== 1) begin n_err++; $display("FAIL fetch_grant_lat got=%0d exp=1", grant_cyc - t0); end
    if (ready_cyc - t0 !== 2) begin n_err++; $display("FAIL fetch_ready_lat got=%0d exp=2", ready_cyc - t0); end
    if (i_rdata_o !== 32'h8C02_0004) begin n_err++; $display("FAIL fetch_rdata got=%h exp=8c020004", i_rdata_o); end
  endtask

  task automatic test_d_write_slow();
    int t0;
    do_reset();
    dmin = 3; dmax = 3;
    d_pend = 1; d_we = 1; d_addr = 32'h0000_0020; d_wdata = 32'hDEAD_BEEF;
    drive();
    t0 = cyc;
    repeat (9) step();
    n_cmp += 3;
    if (grant_cyc - t0 !== 1) begin n_err++; $display("FAIL dwr_grant_lat got=%0d exp=1", grant_cyc - t0); end
    if (ready_cyc - t0 !== 5) begin n_err++; $display("FAIL dwr_ready_lat got=%0d exp=5", ready_cyc - t0); end
    if (grants.size() !== 1) begin n_err++; $display("FAIL dwr_grant_count got=%0d exp=1", grants.size()); end
  endtask

  task automatic test_both_same_cycle();
    do_reset();
    dmin = 0; dmax = 2;
    i_pend = 1; i_addr = 32'h0000_0100;
    d_pend = 1; d_we = 0; d_addr = 32'h0000_0200;
    drive();
    repeat (14) step();
    n_cmp += 2;
    if (grants.size() !== 2) begin n_err++; $display("FAIL both_count got=%0d exp=2", grants.size()); end
    else if (grants[0] !== 1'b1 || grants[1] !== 1'b0) begin
      n_err++; $display("FAIL both_order got=%b%b exp=10", grants[0], grants[1]);
    end
    if (i_pend || d_pend) begin n_err++; $display("FAIL both_served got=%b%b exp=00", i_pend, d_pend); end
  endtask

  task automatic test_streak_guard();
    bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    dmin = 0; dmax = 1; keep_i_pct = 100; keep_d_pct = 100;
    new_i(); new_d();
    drive();
    repeat (60) step();
    n_cmp++;
    if (grants.size() < 10) begin n_err++; $display("FAIL streak_count got=%0d exp>=10", grants.size()); end
    else begin
      for (int k = 0; k < 10; k++) begin
        n_cmp++;
        if (grants[k] !== exp_seq[k]) begin n_err++; $display("FAIL streak_seq idx=%0d got=%b exp=%b", k, grants[k], exp_seq[k]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    dmin = 8; dmax = 8;
    d_pend = 1; d_we = 0; d_addr = 32'h0000_0040;
    drive();
    repeat (3) step();
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    n_cmp += 3;
    if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL midrst_mem_req got=%b exp=0", mem_req_o); end
    if (d_ready_o !== 1'b0) begin n_err++; $display("FAIL midrst_d_ready got=%b exp=0", d_ready_o); end
    if (d_rdata_o !== 32'h0) begin n_err++; $display("FAIL midrst_d_rdata got=%h exp=0", d_rdata_o); end
    rst_i = 1'b1; d_req_i = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL lateack_mem_req got=%b exp=0", mem_req_o); end
    if (d_ready_o !== 1'b0) begin n_err++; $display("FAIL lateack_d_ready got=%b exp=0", d_ready_o); end
    if (d_rdata_o !== 32'h0) begin n_err++; $display("FAIL lateack_d_rdata got=%h exp=0", d_rdata_o); end
    mem_ack_i = 1'b0;
    init_model();
    drive();
  endtask

  task automatic test_random_traffic();
    i_pct = 40; d_pct = 40; keep_i_pct = 30; keep_d_pct = 30; stray_pct = 10; dmin = 0; dmax = 3;
    repeat (1500) step();
    n_cmp++;
    if (grants.size() < 100) begin n_err++; $display("FAIL rand_progress got=%0d exp>=100", grants.size()); end
  endtask

  task automatic test_stray_ack();
    int guard;
    i_pct = 0; d_pct = 0; keep_i_pct = 0; keep_d_pct = 0; stray_pct = 0;
    guard = 0;
    while ((i_pend || d_pend || busy || acked) && guard < 100) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin n_err++; $display("FAIL stray_drain got=timeout exp=idle"); end
    stray_pct = 60;
    repeat (30) step();
    n_cmp += 2;
    if (i_rdata_o !== last_i_rdata) begin n_err++; $display("FAIL stray_i_rdata got=%h exp=%h", i_rdata_o, last_i_rdata); end
    if (d_rdata_o !== last_d_rdata) begin n_err++; $display("FAIL stray_d_rdata got=%h exp=%h", d_rdata_o, last_d_rdata); end
    stray_pct = 0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mmem[k] = $urandom;
    mmem[4] = 32'h8C02_0004;
    cyc = 0;
    init_model();
    test_reset();
    test_single_fetch();
    test_d_write_slow();
    test_both_same_cycle();
    test_streak_guard();
    test_reset_midflight();
    test_random_traffic();
    test_stray_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
